// File: rtl/systolic_job_scheduler.sv
// systolic_job_scheduler: descriptor FIFO that issues matmul jobs to the systolic core and reports completion
module systolic_job_scheduler #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 12,
  parameter int N_MAX   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [ADDR_W-1:0]        job_addr_a,
  input  logic [ADDR_W-1:0]        job_addr_b,
  input  logic [ADDR_W-1:0]        job_addr_c,
  input  logic [3:0]               job_n,
  output logic [TAG_W-1:0]         job_tag_next,
  input  logic                     flush,
  output logic                     core_start,
  output logic [ADDR_W-1:0]        core_addr_a,
  output logic [ADDR_W-1:0]        core_addr_b,
  output logic [ADDR_W-1:0]        core_addr_c,
  output logic [3:0]               core_n,
  input  logic                     core_done,
  output logic                     done_valid,
  output logic [TAG_W-1:0]         done_tag,
  output logic [1:0]               done_status,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic [15:0]              jobs_ok
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, COMPLETE} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] c;
    logic [3:0]        n;
    logic [TAG_W-1:0]  tag;
  } job_t;

  job_t          mem [DEPTH];
  job_t          head;
  logic [PW-1:0] wp, rp;
  logic [WW-1:0] wd;
  state_t        state, state_nxt;
  logic [1:0]    status_nxt;
  logic          push, pop, bad_n;

  assign job_ready = !rst && queue_count < CW'(DEPTH) && !flush;
  assign push      = job_valid && job_ready;
  assign pop       = state == IDLE && queue_count != '0 && !flush;
  assign head      = mem[rp];
  assign bad_n     = head.n == 4'd0 || head.n > 4'(N_MAX);

  always_comb begin
    state_nxt  = state;
    status_nxt = done_status;
    case (state)
      IDLE: if (pop) begin
        state_nxt  = bad_n ? COMPLETE : ISSUE;
        status_nxt = {1'b0, bad_n};
      end
      ISSUE: state_nxt = RUN;
      RUN: if (core_done || wd == WW'(TIMEOUT)) begin
        state_nxt  = COMPLETE;
        status_nxt = core_done ? 2'b00 : 2'b10;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;

  always_ff @(posedge clk)
    if (push) mem[wp] <= {job_addr_a, job_addr_b, job_addr_c, job_n, job_tag_next};

  always_ff @(posedge clk) begin
    if (rst) begin
      wp           <= '0;
      rp           <= '0;
      queue_count  <= '0;
      job_tag_next <= '0;
      jobs_ok      <= '0;
      wd           <= '0;
      core_start   <= 1'b0;
      core_addr_a  <= '0;
      core_addr_b  <= '0;
      core_addr_c  <= '0;
      core_n       <= '0;
      done_valid   <= 1'b0;
      done_tag     <= '0;
      done_status  <= '0;
      busy         <= 1'b0;
    end else begin
      wp           <= wp + PW'(push);
      rp           <= flush ? wp : rp + PW'(pop);
      queue_count  <= flush ? '0 : queue_count + CW'(push) - CW'(pop);
      job_tag_next <= job_tag_next + TAG_W'(push);
      if (pop) {core_addr_a, core_addr_b, core_addr_c, core_n, done_tag} <= head;
      wd           <= state == RUN ? wd + WW'(1) : '0;
      jobs_ok      <= jobs_ok + 16'(state == COMPLETE && done_status == 2'b00);
      core_start   <= state_nxt == ISSUE;
      done_valid   <= state_nxt == COMPLETE;
      done_status  <= status_nxt;
      busy         <= state_nxt != IDLE;
    end
  end
endmodule
